// File: rtl/convertidor_bcd_binario_pkg.sv
// Shared types and constants for the 4-digit BCD to binary converter.
package convertidor_pkg;

  typedef enum logic [1:0] {REPOSO, DESPLAZA, FIN} estado_e;

  localparam int unsigned N_DIGITOS      = 4;
  localparam int unsigned BITS_BCD       = 16;
  localparam int unsigned N_ITER         = 14;
  localparam int unsigned ANCHO_REG      = 30;
  localparam int unsigned BCD_MAX_DIGITO = 9;

  function automatic logic digito_valido(input logic [3:0] d);
    return d <= 4'(BCD_MAX_DIGITO);
  endfunction

endpackage

// File: rtl/convertidor_bcd_binario_if.sv
// Request/result bundle between the digit source (master) and the converter (slave).
interface convertidor_bcd_binario_if #(
  parameter int unsigned ANCHO_SALIDA = 10
);
  logic                    Start;
  logic [3:0]              Millares;
  logic [3:0]              Centenas;
  logic [3:0]              Decenas;
  logic [3:0]              Unidades;
  logic [ANCHO_SALIDA-1:0] N_Binario;
  logic                    Ocupado;
  logic                    Listo;
  logic                    Error_Digito;
  logic                    Desborde;

  modport master (
    output Start, Millares, Centenas, Decenas, Unidades,
    input  N_Binario, Ocupado, Listo, Error_Digito, Desborde
  );

  modport slave (
    input  Start, Millares, Centenas, Decenas, Unidades,
    output N_Binario, Ocupado, Listo, Error_Digito, Desborde
  );
endinterface

// File: rtl/convertidor_bcd_binario_ajuste_digito.sv
// Reverse double-dabble digit correction: subtract 3 from a nibble that reached 8 or more.
module ajuste_digito_bcd (
  input  logic [3:0] dato_i,
  output logic [3:0] dato_o
);
  assign dato_o = (dato_i >= 4'd8) ? dato_i - 4'd3 : dato_i;
endmodule

// File: rtl/convertidor_bcd_binario.sv
// Sequential 4-digit BCD to binary converter (reverse double-dabble) with saturation.
// Define ITERACION_DOBLE_EN to run two shift+correct iterations per clock (7 cycles).
module convertidor_bcd_binario
  import convertidor_pkg::*;
#(
  parameter int unsigned ANCHO_SALIDA = 10
) (
  input logic                      clk,
  input logic                      reset,
  convertidor_bcd_binario_if.slave bus_io
);

`ifdef ITERACION_DOBLE_EN
  localparam logic [3:0] PASOS = 4'(N_ITER / 2);
`else
  localparam logic [3:0] PASOS = 4'(N_ITER);
`endif
  localparam int unsigned LIMITE = (32'd1 << ANCHO_SALIDA) - 32'd1;

  estado_e                 estado_q, estado_d;
  logic [ANCHO_REG-1:0]    sr_q, sr_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ANCHO_SALIDA-1:0] n_binario_q, n_binario_d;
  logic                    ocupado_q, ocupado_d;
  logic                    listo_q, listo_d;
  logic                    error_q, error_d;
  logic                    desborde_q, desborde_d;

  logic [ANCHO_REG-1:0]    desp1, paso1, paso;
  logic [N_ITER-1:0]       valor;
  logic                    digitos_validos;

  // One iteration: shift right, then correct each BCD nibble independently.
  assign desp1 = sr_q >> 1;
  assign paso1[N_ITER-1:0] = desp1[N_ITER-1:0];
  for (genvar i = 0; i < N_DIGITOS; i++) begin : g_ajuste1
    ajuste_digito_bcd u_ajuste (
      .dato_i(desp1[N_ITER+4*i +: 4]),
      .dato_o(paso1[N_ITER+4*i +: 4])
    );
  end

`ifdef ITERACION_DOBLE_EN
  logic [ANCHO_REG-1:0] desp2, paso2;

  assign desp2 = paso1 >> 1;
  assign paso2[N_ITER-1:0] = desp2[N_ITER-1:0];
  for (genvar i = 0; i < N_DIGITOS; i++) begin : g_ajuste2
    ajuste_digito_bcd u_ajuste (
      .dato_i(desp2[N_ITER+4*i +: 4]),
      .dato_o(paso2[N_ITER+4*i +: 4])
    );
  end
  assign paso = paso2;
`else
  assign paso = paso1;
`endif

  assign digitos_validos = digito_valido(bus_io.Millares) && digito_valido(bus_io.Centenas) &&
                           digito_valido(bus_io.Decenas) && digito_valido(bus_io.Unidades);
  assign valor = sr_q[N_ITER-1:0];

  always_comb begin
    estado_d    = estado_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    n_binario_d = n_binario_q;
    ocupado_d   = ocupado_q;
    listo_d     = 1'b0;
    error_d     = error_q;
    desborde_d  = desborde_q;
    case (estado_q)
      REPOSO: begin
        if (bus_io.Start) begin
          if (digitos_validos) begin
            sr_d      = {bus_io.Millares, bus_io.Centenas, bus_io.Decenas, bus_io.Unidades,
                         {N_ITER{1'b0}}};
            cnt_d     = '0;
            ocupado_d = 1'b1;
            estado_d  = DESPLAZA;
          end else begin
            // Rejected request: report immediately, keep the previous result.
            listo_d    = 1'b1;
            error_d    = 1'b1;
            desborde_d = 1'b0;
          end
        end
      end
      DESPLAZA: begin
        sr_d  = paso;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == PASOS - 4'd1) estado_d = FIN;
      end
      FIN: begin
        if (32'(valor) > LIMITE) begin
          n_binario_d = '1;
          desborde_d  = 1'b1;
        end else begin
          n_binario_d = valor[ANCHO_SALIDA-1:0];
          desborde_d  = 1'b0;
        end
        error_d   = 1'b0;
        listo_d   = 1'b1;
        ocupado_d = 1'b0;
        estado_d  = REPOSO;
      end
      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q    <= REPOSO;
      sr_q        <= '0;
      cnt_q       <= '0;
      n_binario_q <= '0;
      ocupado_q   <= 1'b0;
      listo_q     <= 1'b0;
      error_q     <= 1'b0;
      desborde_q  <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      n_binario_q <= n_binario_d;
      ocupado_q   <= ocupado_d;
      listo_q     <= listo_d;
      error_q     <= error_d;
      desborde_q  <= desborde_d;
    end
  end

  assign bus_io.N_Binario    = n_binario_q;
  assign bus_io.Ocupado      = ocupado_q;
  assign bus_io.Listo        = listo_q;
  assign bus_io.Error_Digito = error_q;
  assign bus_io.Desborde     = desborde_q;

endmodule

// File: tb/tb_convertidor_bcd_binario.sv
// Randomized self-checking bench: a 10-bit and a 14-bit converter share stimulus and are
// compared against an arithmetic reference (decimal value, saturation, sticky flags).
module tb_convertidor_bcd_binario;

`ifdef ITERACION_DOBLE_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 15;
`endif

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   last0 = 0;  // result each DUT should be holding
  int   last1 = 0;

  always #5 clk = ~clk;

  convertidor_bcd_binario_if #(.ANCHO_SALIDA(10)) b0 ();
  convertidor_bcd_binario_if #(.ANCHO_SALIDA(14)) b1 ();

  assign b1.Start    = b0.Start;
  assign b1.Millares = b0.Millares;
  assign b1.Centenas = b0.Centenas;
  assign b1.Decenas  = b0.Decenas;
  assign b1.Unidades = b0.Unidades;

  convertidor_bcd_binario #(.ANCHO_SALIDA(10)) u_dut10 (
    .clk   (clk),
    .reset (reset),
    .bus_io(b0)
  );

  convertidor_bcd_binario #(.ANCHO_SALIDA(14)) u_dut14 (
    .clk   (clk),
    .reset (reset),
    .bus_io(b1)
  );

  function automatic int ref_sat(input int v, input int w);
    int lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic ref_desb(input int v, input int w);
    return v > ((1 << w) - 1);
  endfunction

  function automatic logic [17:0] paquete(input int n, input logic desb, input logic err,
                                          input logic ocup, input logic listo);
    return {14'(n), desb, err, ocup, listo};
  endfunction

  function automatic logic [17:0] obs0();
    return {14'(b0.N_Binario), b0.Desborde, b0.Error_Digito, b0.Ocupado, b0.Listo};
  endfunction

  function automatic logic [17:0] obs1();
    return {14'(b1.N_Binario), b1.Desborde, b1.Error_Digito, b1.Ocupado, b1.Listo};
  endfunction

  // Present digits and Start for exactly one accepting edge; returns #1 after that edge.
  task automatic aceptar(input int m, input int c, input int d, input int u);
    @(negedge clk);
    b0.Millares = 4'(m);
    b0.Centenas = 4'(c);
    b0.Decenas  = 4'(d);
    b0.Unidades = 4'(u);
    b0.Start    = 1'b1;
    @(posedge clk);
    #1;
    b0.Start = 1'b0;
  endtask

  // Count edges until Listo (bounded) and Ocupado samples; optionally re-pulse Start.
  task automatic esperar(input int pa, input int pb, output int lat, output int ocup);
    lat  = 0;
    ocup = 0;
    while (b0.Listo !== 1'b1 && lat < 40) begin
      b0.Start = (lat == pa || lat == pb);
      if (b0.Ocupado === 1'b1) ocup++;
      @(posedge clk);
      #1;
      lat++;
    end
    b0.Start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    b0.Start = 1'b0;
    b0.Millares = 4'd0;
    b0.Centenas = 4'd0;
    b0.Decenas  = 4'd0;
    b0.Unidades = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (obs0() !== paquete(0, 0, 0, 0, 0)) begin
      $display("FAIL reset_w10: got %h expected %h", obs0(), paquete(0, 0, 0, 0, 0));
      miscompares++;
    end
    vectors++;
    if (obs1() !== paquete(0, 0, 0, 0, 0)) begin
      $display("FAIL reset_w14: got %h expected %h", obs1(), paquete(0, 0, 0, 0, 0));
      miscompares++;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basico();
    int lat, ocup;
    aceptar(0, 2, 5, 5);
    esperar(-1, -1, lat, ocup);
    vectors++;
    if (lat != LAT || ocup != LAT) begin
      $display("FAIL basic_latency: got lat=%0d busy=%0d expected %0d", lat, ocup, LAT);
      miscompares++;
    end
    vectors++;
    if (obs0() !== paquete(255, 0, 0, 0, 1) || obs1() !== paquete(255, 0, 0, 0, 1)) begin
      $display("FAIL basic_255: got %h/%h expected %h", obs0(), obs1(),
               paquete(255, 0, 0, 0, 1));
      miscompares++;
    end
    @(posedge clk);
    #1;
    vectors++;
    if (obs0() !== paquete(255, 0, 0, 0, 0)) begin
      $display("FAIL basic_pulse: got %h expected %h", obs0(), paquete(255, 0, 0, 0, 0));
      miscompares++;
    end
    last0 = 255;
    last1 = 255;
  endtask

  task automatic test_error_digito();
    int lat, ocup;
    aceptar(1, 10, 0, 0);
    vectors++;
    if (obs0() !== paquete(last0, 0, 1, 0, 1) || obs1() !== paquete(last1, 0, 1, 0, 1)) begin
      $display("FAIL error_report: got %h/%h expected %h", obs0(), obs1(),
               paquete(last0, 0, 1, 0, 1));
      miscompares++;
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (obs0() !== paquete(last0, 0, 1, 0, 0)) begin
        $display("FAIL error_sticky: got %h expected %h", obs0(), paquete(last0, 0, 1, 0, 0));
        miscompares++;
      end
    end
    aceptar(0, 0, 0, 0);
    esperar(-1, -1, lat, ocup);
    vectors++;
    if (lat != LAT || obs0() !== paquete(0, 0, 0, 0, 1) || obs1() !== paquete(0, 0, 0, 0, 1))
    begin
      $display("FAIL error_clear: got lat=%0d %h/%h expected lat=%0d %h", lat, obs0(), obs1(),
               LAT, paquete(0, 0, 0, 0, 1));
      miscompares++;
    end
    last0 = 0;
    last1 = 0;
  endtask

  task automatic test_saturacion();
    int valores[3] = '{1023, 1024, 9999};
    int lat, ocup, v;
    foreach (valores[i]) begin
      v = valores[i];
      aceptar(v / 1000, (v / 100) % 10, (v / 10) % 10, v % 10);
      esperar(-1, -1, lat, ocup);
      last0 = ref_sat(v, 10);
      last1 = ref_sat(v, 14);
      vectors++;
      if (lat != LAT || obs0() !== paquete(last0, ref_desb(v, 10), 0, 0, 1) ||
          obs1() !== paquete(last1, ref_desb(v, 14), 0, 0, 1)) begin
        $display("FAIL saturate_%0d: got lat=%0d %h/%h expected %h/%h", v, lat, obs0(), obs1(),
                 paquete(last0, ref_desb(v, 10), 0, 0, 1),
                 paquete(last1, ref_desb(v, 14), 0, 0, 1));
        miscompares++;
      end
    end
    @(posedge clk);
    #1;
    vectors++;
    if (obs0() !== paquete(1023, 1, 0, 0, 0)) begin
      $display("FAIL overflow_sticky: got %h expected %h", obs0(), paquete(1023, 1, 0, 0, 0));
      miscompares++;
    end
  endtask

  task automatic test_start_ignorado();
    int lat, ocup, extra;
    aceptar(0, 5, 1, 2);
    esperar(3, (LAT > 9) ? 9 : 5, lat, ocup);
    vectors++;
    if (lat != LAT || obs0() !== paquete(512, 0, 0, 0, 1)) begin
      $display("FAIL ignore_start: got lat=%0d %h expected lat=%0d %h", lat, obs0(), LAT,
               paquete(512, 0, 0, 0, 1));
      miscompares++;
    end
    extra = 0;
    repeat (LAT + 5) begin
      @(posedge clk);
      #1;
      if (b0.Listo === 1'b1 || b0.Ocupado === 1'b1) extra++;
    end
    vectors++;
    if (extra != 0) begin
      $display("FAIL ignore_no_queue: got %0d busy/ready cycles expected 0", extra);
      miscompares++;
    end
    last0 = 512;
    last1 = 512;
  endtask

  task automatic test_reset_medio();
    int lat, ocup, vistos;
    aceptar(0, 7, 7, 7);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (obs0() !== paquete(0, 0, 0, 0, 0) || obs1() !== paquete(0, 0, 0, 0, 0)) begin
      $display("FAIL async_reset: got %h/%h expected %h", obs0(), obs1(),
               paquete(0, 0, 0, 0, 0));
      miscompares++;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    vistos = 0;
    repeat (LAT + 5) begin
      @(posedge clk);
      #1;
      if (obs0() !== paquete(0, 0, 0, 0, 0)) vistos++;
    end
    vectors++;
    if (vistos != 0) begin
      $display("FAIL reset_abort: got %0d non-idle cycles expected 0", vistos);
      miscompares++;
    end
    aceptar(0, 7, 7, 7);
    esperar(-1, -1, lat, ocup);
    vectors++;
    if (lat != LAT || ocup != LAT || obs0() !== paquete(777, 0, 0, 0, 1)) begin
      $display("FAIL reset_restart: got lat=%0d busy=%0d %h expected %0d %h", lat, ocup,
               obs0(), LAT, paquete(777, 0, 0, 0, 1));
      miscompares++;
    end
    last0 = 777;
    last1 = 777;
  endtask

  task automatic test_back_to_back();
    int lat, ocup;
    aceptar(0, 1, 0, 0);
    esperar(-1, -1, lat, ocup);
    // Next request raised during the Listo cycle itself.
    b0.Millares = 4'd0;
    b0.Centenas = 4'd0;
    b0.Decenas  = 4'd4;
    b0.Unidades = 4'd2;
    b0.Start    = 1'b1;
    @(posedge clk);
    #1;
    b0.Start = 1'b0;
    vectors++;
    if (obs0() !== paquete(100, 0, 0, 1, 0)) begin
      $display("FAIL b2b_accept: got %h expected %h", obs0(), paquete(100, 0, 0, 1, 0));
      miscompares++;
    end
    esperar(-1, -1, lat, ocup);
    vectors++;
    if (lat != LAT || obs0() !== paquete(42, 0, 0, 0, 1)) begin
      $display("FAIL b2b_result: got lat=%0d %h expected lat=%0d %h", lat, obs0(), LAT,
               paquete(42, 0, 0, 0, 1));
      miscompares++;
    end
    last0 = 42;
    last1 = 42;
  endtask

  task automatic test_aleatorio();
    int bordes[4] = '{0, 1023, 1024, 9999};
    int dg[4];
    int lat, ocup, v;
    logic malo;
    for (int n = 0; n < 80; n++) begin
      v = (n < 4) ? bordes[n] : int'($urandom_range(0, 9999));
      dg[0] = v / 1000;
      dg[1] = (v / 100) % 10;
      dg[2] = (v / 10) % 10;
      dg[3] = v % 10;
      malo = (n >= 4) && ($urandom_range(0, 5) == 0);
      if (malo) dg[$urandom_range(0, 3)] = int'($urandom_range(10, 15));
      aceptar(dg[0], dg[1], dg[2], dg[3]);
      if (malo) begin
        vectors++;
        if (obs0() !== paquete(last0, 0, 1, 0, 1) || obs1() !== paquete(last1, 0, 1, 0, 1))
        begin
          $display("FAIL rand_bad_%0d: got %h/%h expected %h/%h", n, obs0(), obs1(),
                   paquete(last0, 0, 1, 0, 1), paquete(last1, 0, 1, 0, 1));
          miscompares++;
        end
      end else begin
        esperar(-1, -1, lat, ocup);
        last0 = ref_sat(v, 10);
        last1 = ref_sat(v, 14);
        vectors++;
        if (lat != LAT || obs0() !== paquete(last0, ref_desb(v, 10), 0, 0, 1) ||
            obs1() !== paquete(last1, ref_desb(v, 14), 0, 0, 1)) begin
          $display("FAIL rand_%0d_v%0d: got lat=%0d %h/%h expected %h/%h", n, v, lat, obs0(),
                   obs1(), paquete(last0, ref_desb(v, 10), 0, 0, 1),
                   paquete(last1, ref_desb(v, 14), 0, 0, 1));
          miscompares++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basico();
    test_error_digito();
    test_saturacion();
    test_start_ignorado();
    test_reset_medio();
    test_back_to_back();
    test_aleatorio();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/convertidor_bcd_binario.md
Name: convertidor_bcd_binario

Overview:
- Sequential 4-digit BCD to binary converter using reverse double-dabble (shift right, then subtract 3 from any nibble >= 8).
- Takes keypad/display-entered digits (Millares..Unidades) and produces the binary duty-cycle word consumed by the DPWM.
- Start/Ocupado/Listo handshake; result held until the next accepted conversion.
- Validates digits; saturates results that exceed the output width.

Parameters:
- ANCHO_SALIDA, 10, output width in bits; legal range 10..14 (14 bits covers 9999). Saturation limit = 2^ANCHO_SALIDA - 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- Start  input  1  request; sampled only in REPOSO.
- Millares  input  4  BCD thousands digit.
- Centenas  input  4  BCD hundreds digit.
- Decenas  input  4  BCD tens digit.
- Unidades  input  4  BCD units digit.
- N_Binario  output  ANCHO_SALIDA  converted value, registered.
- Ocupado  output  1  high while a conversion is in progress.
- Listo  output  1  one-cycle pulse when a result or error is reported.
- Error_Digito  output  1  last request contained a digit > 9.
- Desborde  output  1  last result exceeded 2^ANCHO_SALIDA - 1 and was saturated.

Behaviour:
- Reset values: all outputs 0, state REPOSO, internal 30-bit shift register 0.
- States:
  - REPOSO: Start=1 at edge k with all digits <= 9 -> load the shift register as {Millares,Centenas,Decenas,Unidades,14'b0}, clear the iteration counter, go to DESPLAZA, Ocupado=1.
  - REPOSO: Start=1 at edge k with any digit > 9 -> stay in REPOSO; at the same edge Listo=1, Error_Digito=1, Desborde=0; N_Binario unchanged.
  - DESPLAZA: per cycle, shift the whole register right by 1; then for each of the 4 BCD nibbles (bits 29:26, 25:22, 21:18, 17:14), if the nibble >= 8, subtract 3. Counter increments; after 14 iterations (edges k+1..k+14) go to FIN.
  - FIN (edge k+15): the low 14 bits hold the binary value V. If V > 2^ANCHO_SALIDA - 1, N_Binario = all ones and Desborde=1; otherwise N_Binario = V[ANCHO_SALIDA-1:0] and Desborde=0. Error_Digito=0, Listo=1 for one cycle, Ocupado=0, go to REPOSO.
- Latency: Listo is high in the cycle after edge k+15. Back-to-back: Start high during the Listo cycle is accepted at the next edge.
- Start while Ocupado=1 is ignored and not queued. Digit inputs are sampled only at the accepting edge; later changes have no effect.
- Error_Digito and Desborde are sticky: they hold until the next Listo.
- Reset mid-conversion: immediate abort; outputs return to 0; no Listo is issued.

Optional Feature:
- Macro ITERACION_DOBLE_EN.
- Defined: DESPLAZA performs two shift+correct iterations per clock, so 7 cycles; FIN at edge k+8, Listo in the cycle after edge k+8. Results are identical to the default mode.
- Undefined: one iteration per clock, latency 15 as above.

Decomposition:
- Package convertidor_pkg contains:
  - state enum {REPOSO, DESPLAZA, FIN};
  - N_DIGITOS=4, BITS_BCD=16, N_ITER=14, ANCHO_REG=30;
  - BCD_MAX_DIGITO=9.
- Sub-module ajuste_digito_bcd: combinational, 4-bit in/out, subtracts 3 if input >= 8. Instantiated 4 times (8 times with ITERACION_DOBLE_EN).

Test Plan:
- Digits 0,2,5,5 with Start 1 cycle -> Ocupado for 15 cycles; then N_Binario=255, Listo 1 cycle, Desborde=0, Error_Digito=0.
- Digits 1,0,2,3 -> 1023 with Desborde=0. Then 1,0,2,4 -> N_Binario=1023, Desborde=1. Then 9,9,9,9 -> 1023, Desborde=1. Repeat 9,9,9,9 with ANCHO_SALIDA=14 -> 9999, Desborde=0.
- After a 255 result, apply digits 1,A,0,0 -> Listo on the cycle after the Start edge, Error_Digito=1, Ocupado never high, N_Binario stays 255. The next valid request 0,0,0,0 -> 0 and Error_Digito clears.
- Start pulsed again at cycles 3 and 9 of a 0,5,1,2 conversion -> ignored; a single Listo at cycle 15 with 512.
- Reset asserted during cycle 7 of a 0,7,7,7 conversion -> all outputs 0 asynchronously, no Listo. A new Start after release -> 777 at the normal latency.
- With ITERACION_DOBLE_EN, sweep all 0..9999 against a reference model -> correct/saturated values, Listo at 8-cycle latency.
